fsquare: RTL and testbench
==========================

Name: fsquare

Overview:
- Pipelined single-precision floating-point squaring unit, y = x*x: the inverse of the table-based sqrt in the FPU.
- Shares the sqrt's IEEE-754 field handling: zero/denormal flush, truncation rounding.
- Sits in the FPU execute stage beside sqrt; a valid/ready stream on both sides so it can stall on writeback backpressure.

Parameters:
- EXP_W, 8, exponent field width
- FRAC_W, 23, fraction field width
- BIAS, 127, exponent bias

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  x is valid this cycle
- in_ready  output  1  unit accepts x this cycle
- x  input  32  IEEE-754 single operand
- out_valid  output  1  y is valid
- out_ready  input  1  consumer accepts y
- y  output  32  IEEE-754 single result
- ovf  output  1  overflow flag, present only with FSQ_OVF_EN

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset clears all stage valid bits. out_valid=0, y=32'h0, ovf=0. Reset mid-operation discards in-flight results.
- Three-stage pipeline S1→S2→S3; S3 drives y/out_valid. Latency is 3 cycles from accept to out_valid with no stall.
- Global advance: adv = ~out_valid | out_ready. All stages shift only when adv=1; in_ready = adv (combinational).
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - A bubble (no input transfer while adv=1) propagates as valid=0.
- Full throughput: one result per cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 freezes all stages; y holds stable; in_ready=0.
- S1:
  - Register the sign-independent fields e=x[30:23] and m={1'b1,x[22:0]}.
  - Set zero flag z = (e==0).
  - Result sign is always 0.
- S2: 48-bit product p = m*m, split as described under Decomposition.
- S3, normalize and truncate (no rounding):
  - If p[47]: frac=p[46:24], c=1.
  - Else: frac=p[45:23], c=0.
  - 10-bit signed E = 2*e - BIAS + c.
- Result selection:
  - z=1 → y=32'h0.
  - E<=0 → y=32'h0 (underflow flush).
  - Otherwise y={1'b0, E[7:0], frac}.
- Overflow (E>=255) without the macro: exponent field is E[7:0], no check.
- Inputs with e==255 are not special-cased without the macro.
- Simultaneous input and output transfer in the same cycle is legal and is the steady state.

Optional Feature:
- Macro FSQ_OVF_EN.
- Defined:
  - Port ovf exists, registered in S3.
  - E>=255 or x[30:23]==255 → y=32'h7F800000, ovf=1.
  - NaN input (e==255, frac!=0) → y=32'h7FC00000, ovf=0.
  - ovf is valid only while out_valid=1.
- Undefined:
  - No ovf port.
  - Raw E[7:0] behaviour as stated under Behaviour; no special-value handling.

Decomposition:
- Shared package fpu_pkg holds:
  - EXP_W, FRAC_W, BIAS
  - typedef packed struct float_t {sign, exp, frac}
  - constants FP_ZERO, FP_PINF, FP_QNAN
  - helper function is_zero_or_denorm
- The sqrt and the other FPU units reuse fpu_pkg.
- One sub-module, fsq_mant_mul: 24x24 unsigned multiplier split into hi/lo 12-bit partial products.
  - Registered at the S1/S2 boundary, summed in S2.
  - Takes adv as its enable.

Test Plan:
- x=32'h40000000 (2.0), out_ready=1 → after 3 cycles y=32'h40800000 (4.0), out_valid=1 for one cycle.
- Back-to-back 32'h3FC00000, 32'h40400000, 32'hC0400000 → y=32'h40100000, 32'h41100000, 32'h41100000 on consecutive cycles.
- x=32'h0C000000 (E=-79), then x=32'h00400000 (denormal) → y=32'h0, 32'h0.
- Hold out_ready=0 for 5 cycles with 4 inputs offered → in_ready drops once S3 is valid. y is stable, no result is lost or duplicated, and the order is preserved on release.
- x=32'h60000000 (E=257) with FSQ_OVF_EN → y=32'h7F800000, ovf=1. Without the macro → y=32'h00800000.
- Assert rst for 1 cycle with 2 results in flight → out_valid=0 and y=0 immediately. No stale output after release; a new x=32'h40000000 yields 32'h40800000 at latency 3.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared IEEE-754 single-precision definitions for the FPU units
// (sqrt, fsquare, ...).
// Contents: field widths and bias, the float_t field view, the canonical
// constant encodings and the zero/denormal test applied before any unit
// touches an operand.
package fpu_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned BIAS   = 127;

    // Mantissa with hidden bit, and the full-width product of two mantissas
    localparam int unsigned MANT_W = FRAC_W + 1;
    localparam int unsigned PROD_W = 2 * MANT_W;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float_t;

    localparam float_t FP_ZERO = float_t'(32'h0000_0000);
    localparam float_t FP_PINF = float_t'(32'h7F80_0000);
    localparam float_t FP_QNAN = float_t'(32'h7FC0_0000);

    // Denormals are flushed, so they are treated exactly like zero
    function automatic logic is_zero_or_denorm(input float_t f);
        return f.exp == '0;
    endfunction

endpackage

// File: rtl/fsq_mant_mul.sv
// fsq_mant_mul: 24x24 unsigned mantissa multiplier for fsquare.
// The operand is split into 12-bit halves; the three partial products
// (hi*hi, hi*lo, lo*lo) are registered when en is high and summed
// combinationally on the far side of the register.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   en        pipeline advance; partial-product registers load only when set
//   a         mantissa operand (squared, so only one input is needed)
//   p         48-bit product of the registered partial products
module fsq_mant_mul
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MANT_W-1:0] a,
    output logic [PROD_W-1:0] p
);

    localparam int unsigned HALF_W = MANT_W / 2;

    logic [HALF_W-1:0] a_hi, a_lo;
    logic [MANT_W-1:0] pp_hh_q, pp_hl_q, pp_ll_q;

    assign a_hi = a[MANT_W-1:HALF_W];
    assign a_lo = a[HALF_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_hh_q <= '0;
            pp_hl_q <= '0;
            pp_ll_q <= '0;
        end else if (en) begin
            pp_hh_q <= {{HALF_W{1'b0}}, a_hi} * {{HALF_W{1'b0}}, a_hi};
            pp_hl_q <= {{HALF_W{1'b0}}, a_hi} * {{HALF_W{1'b0}}, a_lo};
            pp_ll_q <= {{HALF_W{1'b0}}, a_lo} * {{HALF_W{1'b0}}, a_lo};
        end
    end

    // a*a = hh<<24 + 2*hl<<12 + ll; the doubled cross term becomes a shift by 13
    assign p = {pp_hh_q, {MANT_W{1'b0}}}
             + {{(HALF_W-1){1'b0}}, pp_hl_q, {(HALF_W+1){1'b0}}}
             + {{MANT_W{1'b0}}, pp_ll_q};

endmodule

// File: rtl/fsquare.sv
// fsquare: pipelined single-precision squaring unit, y = x*x.
// Three stages S1 (field capture) -> S2 (mantissa product) -> S3 (normalise,
// truncate, select result). All stages advance together when the output is
// empty or being consumed; in_ready is that advance signal.
// Zero/denormal inputs and underflowing results flush to +0; the result sign
// is always 0; no rounding (truncation).
// Optional feature macro FSQ_OVF_EN: adds the ovf port and saturates
// overflow / infinite inputs to +Inf (ovf=1), NaN inputs to a quiet NaN.
// Without it the exponent field simply wraps and e==255 is not special.
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   in_valid, in_ready   input handshake for operand x
//   x                    IEEE-754 single operand
//   out_valid, out_ready output handshake for result y
//   y                    IEEE-754 single result
//   ovf                  overflow flag (FSQ_OVF_EN only), valid with out_valid
module fsquare
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef FSQ_OVF_EN
    output logic        ovf,
`endif
    output logic [31:0] y
);

    // Signed exponent of the square: needs two extra bits over EXP_W
    localparam int unsigned EW = EXP_W + 2;

    float_t xin;
    logic   adv;

    logic              s1_valid, s1_zero;
    logic [EXP_W-1:0]  s1_exp;
    logic [MANT_W-1:0] s1_mant;

    logic              s2_valid, s2_zero;
    logic [EXP_W-1:0]  s2_exp;
    logic [PROD_W-1:0] s2_prod;

    logic              s3_valid;
    float_t            y_q, y_d;
    logic              ovf_d;
    logic              carry, underflow;
    logic [FRAC_W-1:0] norm_frac;
    logic [EW-1:0]     exp_full;

`ifdef FSQ_OVF_EN
    logic s1_inf, s1_nan, s2_inf, s2_nan, ovf_q, overflow;
`endif

    logic unused_bits;

    assign xin       = x;
    assign adv       = ~s3_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = s3_valid;
    assign y         = y_q;
    assign unused_bits = ^{xin.sign, s2_prod[FRAC_W-1:0], ovf_d};

    // S1: capture magnitude fields; a bubble enters as valid=0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_zero  <= is_zero_or_denorm(xin);
            s1_exp   <= xin.exp;
            s1_mant  <= {1'b1, xin.frac};
        end
    end

    fsq_mant_mul u_mant_mul (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .a   (s1_mant),
        .p   (s2_prod)
    );

    // S2: control that travels alongside the registered partial products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_zero  <= 1'b0;
            s2_exp   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_zero  <= s1_zero;
            s2_exp   <= s1_exp;
        end
    end

`ifdef FSQ_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_inf <= 1'b0;
            s1_nan <= 1'b0;
            s2_inf <= 1'b0;
            s2_nan <= 1'b0;
        end else if (adv) begin
            s1_inf <= (xin.exp == '1);
            s1_nan <= (xin.exp == '1) & (xin.frac != '0);
            s2_inf <= s1_inf;
            s2_nan <= s1_nan;
        end
    end
`endif

    // S3 next-state: the product of two [1,2) mantissas lies in [1,4),
    // so normalising is at most one right shift (carry)
    always_comb begin
        carry     = s2_prod[PROD_W-1];
        norm_frac = carry ? s2_prod[PROD_W-2 -: FRAC_W] : s2_prod[PROD_W-3 -: FRAC_W];
        exp_full  = {1'b0, s2_exp, 1'b0} - EW'(BIAS) + {{(EW-1){1'b0}}, carry};
        underflow = exp_full[EW-1] | (exp_full == '0);
        ovf_d     = 1'b0;
        y_d       = FP_ZERO;
`ifdef FSQ_OVF_EN
        overflow  = ~exp_full[EW-1] & (exp_full >= EW'((1 << EXP_W) - 1));
        if (s2_zero) begin
            y_d = FP_ZERO;
        end else if (s2_nan) begin
            y_d = FP_QNAN;
        end else if (s2_inf | overflow) begin
            y_d   = FP_PINF;
            ovf_d = 1'b1;
        end else if (!underflow) begin
            y_d.exp  = exp_full[EXP_W-1:0];
            y_d.frac = norm_frac;
        end
`else
        if (!s2_zero && !underflow) begin
            y_d.exp  = exp_full[EXP_W-1:0];
            y_d.frac = norm_frac;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            y_q      <= FP_ZERO;
        end else if (adv) begin
            s3_valid <= s2_valid;
            y_q      <= y_d;
        end
    end

`ifdef FSQ_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end
    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_fsquare.sv
// tb_fsquare: directed bench for fsquare with a scoreboard fed by a
// behavioural square model (leading-one search on the exact 48-bit product).
module tb_fsquare;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] y;
`ifdef FSQ_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q[$];   // {ovf, y} in issue order
    logic        stall_prev = 1'b0;
    logic [31:0] y_prev = '0;

    always #5 clk = ~clk;

    fsquare dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FSQ_OVF_EN
        .ovf       (ovf),
`endif
        .y         (y)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Square computed from the real-number view: value = m^2 * 2^(2(e-127)-46)
    function automatic logic [32:0] model(input logic [31:0] v);
        int          e, msb, ex;
        longint      m, p, fr;
        logic [31:0] r;
        logic        o;
        e   = int'(v[30:23]);
        m   = longint'({1'b1, v[22:0]});
        p   = m * m;
        msb = 0;
        for (int i = 0; i < 48; i++) if (p[i]) msb = i;
        ex  = 2 * (e - 127) + (msb - 46) + 127;
        fr  = (p >> (msb - 23)) & 64'h7F_FFFF;
        o   = 1'b0;
        if (e == 0) r = 32'h0;
`ifdef FSQ_OVF_EN
        else if (e == 255 && v[22:0] != 0) r = 32'h7FC0_0000;
        else if (e == 255 || ex >= 255) begin
            r = 32'h7F80_0000;
            o = 1'b1;
        end
`endif
        else if (ex <= 0) r = 32'h0;
        else r = {1'b0, ex[7:0], fr[22:0]};
        return {o, r};
    endfunction

    // Compare process: scoreboard on every output-valid cycle, stall rules
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("y", y, exp_q[0][31:0]);
`ifdef FSQ_OVF_EN
                    check("ovf", 32'(ovf), 32'(exp_q[0][32]));
`endif
                    if (out_ready) void'(exp_q.pop_front());
                end
                if (!out_ready) check("in_ready_stall", 32'(in_ready), 32'd0);
            end
            if (stall_prev) check("y_hold", y, y_prev);
            if (in_valid && in_ready) exp_q.push_back(model(x));
            stall_prev = out_valid && !out_ready;
            y_prev     = y;
        end
    end

    task automatic send(input logic [31:0] v);
        int n = 0;
        x        = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Cycles (sampled at negedge) from the accepting edge until out_valid
    task automatic measure_latency(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
    endtask

    logic [31:0] b2b_req [3] = '{32'h4010_0000, 32'h4110_0000, 32'h4110_0000};
    int lat;

    initial begin
        // Pin the model against hand-computed squares
        check("model_2p0",    model(32'h4000_0000)[31:0], 32'h4080_0000);
        check("model_1p5",    model(32'h3FC0_0000)[31:0], 32'h4010_0000);
        check("model_3p0",    model(32'h4040_0000)[31:0], 32'h4110_0000);
        check("model_m3p0",   model(32'hC040_0000)[31:0], 32'h4110_0000);
        check("model_uflow",  model(32'h0C00_0000)[31:0], 32'h0000_0000);
        check("model_denorm", model(32'h0040_0000)[31:0], 32'h0000_0000);
`ifdef FSQ_OVF_EN
        check("model_oflow",  model(32'h6000_0000)[31:0], 32'h7F80_0000);
`else
        check("model_oflow",  model(32'h6000_0000)[31:0], 32'h0080_0000);
`endif

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", y, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency and single-cycle valid
        send(32'h4000_0000);
        measure_latency(lat);
        check("latency", 32'(lat), 32'd3);
        check("y_2p0", y, 32'h4080_0000);
        @(negedge clk);
        check("single_valid", 32'(out_valid), 32'd0);
        drain();

        // Back-to-back: results on consecutive cycles
        send(32'h3FC0_0000);
        send(32'h4040_0000);
        send(32'hC040_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_y", y, b2b_req[i]);
        end
        drain();

        // Underflow flush, denormal flush, exponent overflow
        send(32'h0C00_0000);
        send(32'h0040_0000);
        send(32'h6000_0000);
        drain();

        // Stall for several cycles with four inputs offered
        fork
            begin
                send(32'h3FC0_0000);
                send(32'h4040_0000);
                send(32'h4000_0000);
                send(32'h3F80_0000);
            end
            begin
                out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1;
                check("stall_in_ready", 32'(in_ready), 32'd0);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with results in flight
        send(32'h4040_0000);
        send(32'h3FC0_0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_y", y, 32'h0);
        exp_q.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send(32'h4000_0000);
        measure_latency(lat);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_y", y, 32'h4080_0000);
        drain();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
